// File: rtl/frame_payload_splitter.sv
// frame_payload_splitter: deserialises a framed narrow stream into header address, pixel payload and audio payload.
// Frames are delimited by axiiv going low; malformed frames are flagged through frame_err on frame_done.
module frame_payload_splitter #(
    parameter int IN_WIDTH    = 2,
    parameter int ADDR_BITS   = 24,
    parameter int PIXEL_BYTES = 320,
    parameter int AUDIO_BYTES = 64,
    localparam int PW = PIXEL_BYTES > 1 ? $clog2(PIXEL_BYTES) : 1,
    localparam int AW = AUDIO_BYTES > 0 ? $clog2(AUDIO_BYTES + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 axiiv,
    input  logic [IN_WIDTH-1:0]  axiid,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 addr_valid,
    output logic [7:0]           pixel,
    output logic                 pixel_valid,
    output logic [PW-1:0]        pixel_index,
    output logic [7:0]           audio,
    output logic                 audio_valid,
    output logic [AW-1:0]        audio_index,
    output logic                 frame_done,
    output logic                 frame_err
);
    localparam int BEATS      = 8 / IN_WIDTH;
    localparam int ADDR_BEATS = ADDR_BITS / IN_WIDTH;
    localparam int ACC_W      = ADDR_BITS > 8 ? ADDR_BITS : 8;
    localparam int MAXB       = ADDR_BEATS > BEATS ? ADDR_BEATS : BEATS;
    localparam int BW         = $clog2(MAXB + 1);
    localparam int CW         = $clog2(PIXEL_BYTES + AUDIO_BYTES + 1);
    localparam logic [BW-1:0] ADDR_LAST = BW'(ADDR_BEATS - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(BEATS - 1);
    localparam logic [CW-1:0] PIX_LAST  = CW'(PIXEL_BYTES - 1);
    localparam logic [CW-1:0] AUD_MAX   = CW'(AUDIO_BYTES);

    typedef enum logic [2:0] {SYNC, ADDR, PIXEL, AUDIO, DROP} state_t;

    state_t                  state;
    logic [ACC_W-IN_WIDTH-1:0] acc;
    logic [ACC_W-1:0]        shifted;
    logic [BW-1:0]           beat_cnt;
    logic [CW-1:0]           byte_cnt;
    logic                    beat_last;

    always_comb begin
        shifted   = {acc, axiid};
        beat_last = beat_cnt == BYTE_LAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SYNC;
            acc         <= '0;
            beat_cnt    <= '0;
            byte_cnt    <= '0;
            addr        <= '0;
            addr_valid  <= 1'b0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            audio       <= '0;
            audio_valid <= 1'b0;
            audio_index <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            addr_valid  <= 1'b0;
            pixel_valid <= 1'b0;
            audio_valid <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            if (axiiv)
                acc <= shifted[ACC_W-IN_WIDTH-1:0];
            if (!axiiv) begin
                // Any low cycle ends the frame; an idle ADDR cycle with no beats is not a frame.
                state      <= ADDR;
                beat_cnt   <= '0;
                byte_cnt   <= '0;
                frame_done <= state != SYNC && !(state == ADDR && beat_cnt == '0);
                frame_err  <= (state == ADDR && beat_cnt != '0) || state == PIXEL || state == DROP
                              || (state == AUDIO && beat_cnt != '0);
            end else begin
                case (state)
                    ADDR: begin
                        beat_cnt <= beat_cnt == ADDR_LAST ? '0 : beat_cnt + 1'b1;
                        if (beat_cnt == ADDR_LAST) begin
                            addr       <= shifted[ADDR_BITS-1:0];
                            addr_valid <= 1'b1;
                            state      <= PIXEL;
                        end
                    end
                    PIXEL: begin
                        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
                        if (beat_last) begin
                            pixel       <= shifted[7:0];
                            pixel_valid <= 1'b1;
                            pixel_index <= byte_cnt[PW-1:0];
                            byte_cnt    <= byte_cnt == PIX_LAST ? '0 : byte_cnt + 1'b1;
                            state       <= byte_cnt == PIX_LAST ? AUDIO : PIXEL;
                        end
                    end
                    AUDIO: begin
                        if (byte_cnt == AUD_MAX) begin
                            state <= DROP;
                        end else begin
                            beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
                            if (beat_last) begin
                                audio       <= shifted[7:0];
                                audio_valid <= 1'b1;
                                audio_index <= byte_cnt[AW-1:0];
                                byte_cnt    <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_frame_payload_splitter.sv
// tb_frame_payload_splitter: scoreboard bench for a dibit instance and a byte-wide instance of the splitter.
module tb_frame_payload_splitter;
    typedef struct {
        int          kind;
        logic [31:0] val;
        int          due;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  qa[$];
    ev_t  qb[$];
    ev_t  ea, eb;

    logic        a_av = 1'b0;
    logic [1:0]  a_ad = '0;
    logic [23:0] a_addr;
    logic        a_addr_valid, a_pixel_valid, a_audio_valid, a_frame_done, a_frame_err;
    logic [7:0]  a_pixel, a_audio;
    logic [1:0]  a_pixel_index, a_audio_index;

    logic        b_av = 1'b0;
    logic [7:0]  b_ad = '0;
    logic [23:0] b_addr;
    logic        b_addr_valid, b_pixel_valid, b_audio_valid, b_frame_done, b_frame_err;
    logic [7:0]  b_pixel, b_audio;
    logic [1:0]  b_pixel_index, b_audio_index;

    frame_payload_splitter #(.IN_WIDTH(2), .ADDR_BITS(24), .PIXEL_BYTES(4), .AUDIO_BYTES(2)) dut_a (
        .clk(clk), .rst(rst), .axiiv(a_av), .axiid(a_ad),
        .addr(a_addr), .addr_valid(a_addr_valid),
        .pixel(a_pixel), .pixel_valid(a_pixel_valid), .pixel_index(a_pixel_index),
        .audio(a_audio), .audio_valid(a_audio_valid), .audio_index(a_audio_index),
        .frame_done(a_frame_done), .frame_err(a_frame_err)
    );

    frame_payload_splitter #(.IN_WIDTH(8), .ADDR_BITS(24), .PIXEL_BYTES(4), .AUDIO_BYTES(2)) dut_b (
        .clk(clk), .rst(rst), .axiiv(b_av), .axiid(b_ad),
        .addr(b_addr), .addr_valid(b_addr_valid),
        .pixel(b_pixel), .pixel_valid(b_pixel_valid), .pixel_index(b_pixel_index),
        .audio(b_audio), .audio_valid(b_audio_valid), .audio_index(b_audio_index),
        .frame_done(b_frame_done), .frame_err(b_frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Expected strobes are due one cycle after the beat that completes them.
    task automatic push_a(input int kind, input logic [31:0] val);
        qa.push_back('{kind, val, cyc + 1});
    endtask

    task automatic push_b(input int kind, input logic [31:0] val);
        qb.push_back('{kind, val, cyc + 1});
    endtask

    task automatic beat_a(input logic [1:0] d);
        @(posedge clk); #1;
        a_av = 1'b1;
        a_ad = d;
    endtask

    task automatic idle_a();
        @(posedge clk); #1;
        a_av = 1'b0;
    endtask

    task automatic beat_b(input logic [7:0] d);
        @(posedge clk); #1;
        b_av = 1'b1;
        b_ad = d;
    endtask

    task automatic idle_b();
        @(posedge clk); #1;
        b_av = 1'b0;
    endtask

    task automatic send_addr_a(input logic [23:0] a);
        for (int i = 0; i < 12; i++) begin
            beat_a(2'(a >> (22 - 2 * i)));
            if (i == 11) push_a(0, 32'(a));
        end
    endtask

    // Payload byte k carries (k+1)*0x11; bytes 0..3 are pixels, 4..5 audio, later bytes dropped.
    task automatic frame_a(input logic [23:0] a, input int nbytes, input int extra);
        logic [7:0] v;
        send_addr_a(a);
        for (int k = 0; k < nbytes; k++) begin
            v = 8'((k + 1) * 17);
            for (int j = 0; j < 4; j++) beat_a(2'(v >> (6 - 2 * j)));
            if (k < 4) push_a(1, 32'(k * 256 + int'(v)));
            else if (k < 6) push_a(2, 32'((k - 4) * 256 + int'(v)));
        end
        for (int j = 0; j < extra; j++) beat_a(2'(j + 1));
        idle_a();
        push_a(3, 32'(nbytes < 4 || nbytes > 6 || extra != 0));
        idle_a();
        idle_a();
    endtask

    task automatic frame_b(input logic [23:0] a);
        for (int i = 0; i < 3; i++) begin
            beat_b(8'(a >> (16 - 8 * i)));
            if (i == 2) push_b(0, 32'(a));
        end
        for (int k = 0; k < 4; k++) begin
            beat_b(8'(8'hA0 + k));
            push_b(1, 32'(k * 256 + 8'hA0 + k));
        end
        idle_b();
        push_b(3, 32'd0);
        idle_b();
    endtask

    always @(negedge clk) begin
        if (qa.size() != 0 && cyc > qa[0].due) begin
            check("a_missing_event", 32'(cyc), 32'(qa[0].due));
            ea = qa.pop_front();
        end
        if (a_addr_valid | a_pixel_valid | a_audio_valid | a_frame_done) begin
            check("a_exclusive", 32'(a_addr_valid) + 32'(a_pixel_valid) + 32'(a_audio_valid) + 32'(a_frame_done), 32'd1);
            if (qa.size() == 0) begin
                check("a_spurious_strobe", {a_addr_valid, a_pixel_valid, a_audio_valid, a_frame_done}, 32'd0);
            end else begin
                ea = qa.pop_front();
                check("a_kind", a_frame_done ? 32'd3 : a_audio_valid ? 32'd2 : a_pixel_valid ? 32'd1 : 32'd0, 32'(ea.kind));
                check("a_latency", 32'(cyc), 32'(ea.due));
                check("a_value", a_frame_done ? 32'(a_frame_err) : a_audio_valid ? 32'({a_audio_index, a_audio}) :
                      a_pixel_valid ? 32'({a_pixel_index, a_pixel}) : 32'(a_addr), ea.val);
            end
        end
    end

    always @(negedge clk) begin
        if (qb.size() != 0 && cyc > qb[0].due) begin
            check("b_missing_event", 32'(cyc), 32'(qb[0].due));
            eb = qb.pop_front();
        end
        if (b_addr_valid | b_pixel_valid | b_audio_valid | b_frame_done) begin
            check("b_exclusive", 32'(b_addr_valid) + 32'(b_pixel_valid) + 32'(b_audio_valid) + 32'(b_frame_done), 32'd1);
            if (qb.size() == 0) begin
                check("b_spurious_strobe", {b_addr_valid, b_pixel_valid, b_audio_valid, b_frame_done}, 32'd0);
            end else begin
                eb = qb.pop_front();
                check("b_kind", b_frame_done ? 32'd3 : b_audio_valid ? 32'd2 : b_pixel_valid ? 32'd1 : 32'd0, 32'(eb.kind));
                check("b_latency", 32'(cyc), 32'(eb.due));
                check("b_value", b_frame_done ? 32'(b_frame_err) : b_audio_valid ? 32'({b_audio_index, b_audio}) :
                      b_pixel_valid ? 32'({b_pixel_index, b_pixel}) : 32'(b_addr), eb.val);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_a", 32'(|{a_addr, a_addr_valid, a_pixel, a_pixel_valid, a_pixel_index,
              a_audio, a_audio_valid, a_audio_index, a_frame_done, a_frame_err}), 32'd0);
        check("reset_outputs_b", 32'(|{b_addr, b_addr_valid, b_pixel, b_pixel_valid, b_pixel_index,
              b_audio, b_audio_valid, b_audio_index, b_frame_done, b_frame_err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_a();
        idle_a();

        frame_a(24'hABCDEF, 6, 0);
        frame_a(24'h123456, 2, 0);
        frame_a(24'h0F0F0F, 7, 0);
        frame_a(24'hABCDEF, 6, 0);
        frame_a(24'h654321, 6, 3);
        frame_a(24'h111111, 5, 2);
        frame_a(24'h222222, 4, 0);
        frame_a(24'hFFFFFF, 5, 0);
        for (int i = 0; i < 5; i++) beat_a(2'(i));
        idle_a();
        push_a(3, 32'd1);
        idle_a();

        // Reset in the middle of pixel byte 1; the stream keeps flowing until one low cycle.
        send_addr_a(24'hC0FFEE);
        for (int j = 0; j < 4; j++) beat_a(2'(8'h11 >> (6 - 2 * j)));
        push_a(1, 32'h011);
        beat_a(2'b00);
        beat_a(2'b10);
        @(posedge clk); #1;
        rst = 1'b1;
        a_ad = 2'b11;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_av = 1'b1;
            a_ad = 2'($urandom_range(0, 3));
            @(negedge clk);
            check("a_reset_quiet", 32'(|{a_addr, a_addr_valid, a_pixel, a_pixel_valid, a_pixel_index,
                  a_audio, a_audio_valid, a_audio_index, a_frame_done, a_frame_err}), 32'd0);
            @(posedge clk); #1;
        end
        a_av = 1'b0;
        idle_a();
        frame_a(24'hABCDEF, 6, 0);

        idle_b();
        frame_b(24'hABCDEF);
        frame_b(24'h010203);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
